// File: rtl/lut_sweep_pkg.sv
// Shared types and constants for the LUT sweep evaluator.
package lut_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } sweep_state_t;

  // f = ~b~c | ~a.b | a.c with {a,b,c} = minterm index
  localparam logic [7:0] TT_DEFAULT_3 = 8'hBD;

endpackage

// File: rtl/lut_core.sv
// Truth-table storage with serial shift-in and two independent read ports.
module lut_core
  import lut_sweep_pkg::*;
#(
  parameter int N = 3,
  parameter int DEPTH = 1 << N,
  parameter logic [DEPTH-1:0] INIT_TT = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         shift_en,
  input  logic         shift_bit,
  input  logic [N-1:0] eval_idx,
  output logic         eval_bit,
  input  logic [N-1:0] sweep_idx,
  output logic         sweep_bit
);

  logic [DEPTH-1:0] tt;

  // New bits enter at the top and walk down, so the first bit sent ends up in tt[0]
  always_ff @(posedge clk) begin
    if (rst) begin
      tt <= INIT_TT;
    end else if (shift_en) begin
      tt <= {shift_bit, tt[DEPTH-1:1]};
    end
  end

  assign eval_bit  = tt[eval_idx];
  assign sweep_bit = tt[sweep_idx];

endmodule

// File: rtl/lut_sweep_eval.sv
// Programmable N-input Boolean function with registered evaluation and a
// sweep engine that streams every minterm result and counts the ones.
module lut_sweep_eval
  import lut_sweep_pkg::*;
#(
  parameter int N = 3,
  parameter logic [(1<<N)-1:0] INIT_TT = TT_DEFAULT_3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] in_vec,
  output logic         f,
  input  logic         load_en,
  input  logic         load_bit,
  input  logic         start,
  output logic         busy,
  output logic         sweep_valid,
  output logic [N-1:0] sweep_idx,
  output logic         sweep_f,
  output logic         done,
  output logic [N:0]   ones_cnt
);

  localparam int DEPTH = 1 << N;

  sweep_state_t state;
  sweep_state_t state_next;

  logic [N-1:0] idx;
  logic         eval_bit;
  logic         sweep_bit;
  logic         can_accept;
  logic         load_ok;
  logic         start_ok;
  logic         last_idx;

  // The table may only change while no sweep is reading it; load beats start
  assign can_accept = (state == IDLE) || (state == DONE);
  assign load_ok    = load_en && can_accept;
  assign start_ok   = start && !load_en && can_accept;
  assign last_idx   = (idx == N'(DEPTH - 1));

  lut_core #(
    .N       (N),
    .DEPTH   (DEPTH),
    .INIT_TT (INIT_TT)
  ) u_core (
    .clk       (clk),
    .rst       (rst),
    .shift_en  (load_ok),
    .shift_bit (load_bit),
    .eval_idx  (in_vec),
    .eval_bit  (eval_bit),
    .sweep_idx (idx),
    .sweep_bit (sweep_bit)
  );

  // Evaluation path runs every cycle regardless of sweep activity
  always_ff @(posedge clk) begin
    if (rst) begin
      f <= 1'b0;
    end else begin
      f <= eval_bit;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state: DONE behaves like IDLE for a new start, otherwise falls back to IDLE
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_ok) state_next = SWEEP;
      SWEEP:   if (last_idx) state_next = DONE;
      DONE:    state_next = start_ok ? SWEEP : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs are decoded straight from state so they line up with the sweep index
  always_comb begin
    busy        = 1'b0;
    sweep_valid = 1'b0;
    done        = 1'b0;
    sweep_idx   = idx;
    sweep_f     = sweep_bit;
    case (state)
      SWEEP: begin
        busy        = 1'b1;
        sweep_valid = 1'b1;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Minterm counter and ones accumulator; the count holds until the next accepted start
  always_ff @(posedge clk) begin
    if (rst) begin
      idx      <= '0;
      ones_cnt <= '0;
    end else if (start_ok) begin
      idx      <= '0;
      ones_cnt <= '0;
    end else if (state == SWEEP) begin
      idx      <= idx + N'(1);
      ones_cnt <= ones_cnt + (N+1)'(sweep_bit);
    end
  end

endmodule

// File: tb/tb_lut_sweep_eval.sv
// Self-checking bench for lut_sweep_eval: directed steps plus randomized tables.
module tb_lut_sweep_eval;

  localparam logic [7:0] INIT3 = 8'hBD;

  logic       clk;
  logic       rst;
  logic [2:0] in_vec;
  logic       f;
  logic       load_en;
  logic       load_bit;
  logic       start;
  logic       busy;
  logic       sweep_valid;
  logic [2:0] sweep_idx;
  logic       sweep_f;
  logic       done;
  logic [3:0] ones_cnt;

  logic [3:0] in_vec4;
  logic       f4;
  logic       load_en4;
  logic       load_bit4;
  logic       start4;
  logic       busy4;
  logic       valid4;
  logic [3:0] idx4;
  logic       sf4;
  logic       done4;
  logic [4:0] ones4;

  int total = 0;
  int bad = 0;
  logic [7:0] m_tt;

  lut_sweep_eval dut (
    .clk         (clk),
    .rst         (rst),
    .in_vec      (in_vec),
    .f           (f),
    .load_en     (load_en),
    .load_bit    (load_bit),
    .start       (start),
    .busy        (busy),
    .sweep_valid (sweep_valid),
    .sweep_idx   (sweep_idx),
    .sweep_f     (sweep_f),
    .done        (done),
    .ones_cnt    (ones_cnt)
  );

  lut_sweep_eval #(
    .N       (4),
    .INIT_TT (16'hFFFF)
  ) dut4 (
    .clk         (clk),
    .rst         (rst),
    .in_vec      (in_vec4),
    .f           (f4),
    .load_en     (load_en4),
    .load_bit    (load_bit4),
    .start       (start4),
    .busy        (busy4),
    .sweep_valid (valid4),
    .sweep_idx   (idx4),
    .sweep_f     (sf4),
    .done        (done4),
    .ones_cnt    (ones4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic le, input logic lb, input logic [2:0] iv);
    start    = s;
    load_en  = le;
    load_bit = lb;
    in_vec   = iv;
    tick();
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic evalAll(input string tag);
    for (int v = 0; v < 8; v++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 3'(v));
      checkOutput(tag, 32'(f), 32'(m_tt[v]));
    end
  endtask

  task automatic sweepCheck(input string tag, input logic noisy);
    int ones;
    ones = 0;
    for (int k = 0; k < 8; k++) if (m_tt[k]) ones++;
    applyStimulus(1'b1, 1'b0, 1'b0, 3'd0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
    for (int k = 0; k < 8; k++) begin
      checkOutput({tag, "_valid"}, 32'(sweep_valid), 32'd1);
      checkOutput({tag, "_idx"}, 32'(sweep_idx), 32'(k));
      checkOutput({tag, "_sf"}, 32'(sweep_f), 32'(m_tt[k]));
      checkOutput({tag, "_early_done"}, 32'(done), 32'd0);
      applyStimulus(noisy, noisy, 1'b0, 3'(k));
    end
    checkOutput({tag, "_done"}, 32'(done), 32'd1);
    checkOutput({tag, "_busy_end"}, 32'(busy), 32'd0);
    checkOutput({tag, "_valid_end"}, 32'(sweep_valid), 32'd0);
    checkOutput({tag, "_ones"}, 32'(ones_cnt), 32'(ones));
    applyStimulus(1'b0, 1'b0, 1'b0, 3'd0);
    checkOutput({tag, "_done_pulse"}, 32'(done), 32'd0);
    checkOutput({tag, "_ones_hold"}, 32'(ones_cnt), 32'(ones));
  endtask

  initial begin
    logic [7:0] r;
    logic [7:0] pat;
    rst       = 1'b1;
    start     = 1'b0;
    load_en   = 1'b0;
    load_bit  = 1'b0;
    in_vec    = 3'd0;
    in_vec4   = 4'd0;
    start4    = 1'b0;
    load_en4  = 1'b0;
    load_bit4 = 1'b0;
    m_tt      = INIT3;
    tick();
    tick();

    checkOutput("rst_f", 32'(f), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_valid", 32'(sweep_valid), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_ones", 32'(ones_cnt), 32'd0);
    checkOutput("rst_idx", 32'(sweep_idx), 32'd0);
    checkOutput("rst_sf", 32'(sweep_f), 32'(m_tt[0]));
    checkOutput("rst_busy4", 32'(busy4), 32'd0);
    rst = 1'b0;

    $display("[TB] default table evaluation");
    evalAll("dflt_eval");

    $display("[TB] default table sweep");
    sweepCheck("dflt", 1'b0);
    checkOutput("dflt_ones6", 32'(ones_cnt), 32'd6);

    $display("[TB] serial load of 8'h96");
    pat = 8'h96;
    for (int k = 0; k < 8; k++) applyStimulus(1'b0, 1'b1, pat[k], 3'd0);
    m_tt = pat;
    applyStimulus(1'b0, 1'b0, 1'b0, 3'd0);
    sweepCheck("ld96", 1'b0);
    checkOutput("ld96_ones4", 32'(ones_cnt), 32'd4);
    applyStimulus(1'b0, 1'b0, 1'b0, 3'b111);
    checkOutput("ld96_f7", 32'(f), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 3'b011);
    checkOutput("ld96_f3", 32'(f), 32'd0);

    $display("[TB] start and load ignored during a sweep");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_tt = INIT3;
    sweepCheck("noisy", 1'b1);
    checkOutput("noisy_ones6", 32'(ones_cnt), 32'd6);
    evalAll("noisy_eval");

    $display("[TB] start with load in the same idle cycle");
    applyStimulus(1'b1, 1'b1, 1'b0, 3'd0);
    checkOutput("ldstart_busy", 32'(busy), 32'd0);
    checkOutput("ldstart_valid", 32'(sweep_valid), 32'd0);
    m_tt = m_tt >> 1;
    evalAll("ldstart_eval");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_tt = INIT3;

    $display("[TB] reset in the middle of a sweep");
    applyStimulus(1'b1, 1'b0, 1'b0, 3'd0);
    for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b0, 1'b0, 3'd0);
    checkOutput("abort_idx3", 32'(sweep_idx), 32'd3);
    checkOutput("abort_ones2", 32'(ones_cnt), 32'd2);
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 3'd1);
    rst = 1'b0;
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_valid", 32'(sweep_valid), 32'd0);
    checkOutput("abort_ones", 32'(ones_cnt), 32'd0);
    checkOutput("abort_done", 32'(done), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 3'd1);
    checkOutput("abort_f1", 32'(f), 32'(m_tt[1]));
    checkOutput("abort_f1_zero", 32'(f), 32'd0);
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 3'd1);
      checkOutput("abort_no_done", 32'(done), 32'd0);
    end

    $display("[TB] randomized tables");
    for (int rep = 0; rep < 4; rep++) begin
      r = 8'($urandom);
      for (int k = 0; k < 8; k++) applyStimulus(1'b0, 1'b1, r[k], 3'd0);
      m_tt = r;
      sweepCheck("rnd", 1'b0);
      for (int k = 0; k < 8; k++) begin
        logic [2:0] v;
        v = 3'($urandom_range(0, 7));
        applyStimulus(1'b0, 1'b0, 1'b0, v);
        checkOutput("rnd_eval", 32'(f), 32'(m_tt[v]));
      end
    end

    $display("[TB] N=4 all-ones sweep");
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    checkOutput("n4_busy", 32'(busy4), 32'd1);
    for (int k = 0; k < 16; k++) begin
      checkOutput("n4_valid", 32'(valid4), 32'd1);
      checkOutput("n4_idx", 32'(idx4), 32'(k));
      checkOutput("n4_sf", 32'(sf4), 32'd1);
      checkOutput("n4_early_done", 32'(done4), 32'd0);
      tick();
    end
    checkOutput("n4_done", 32'(done4), 32'd1);
    checkOutput("n4_busy_end", 32'(busy4), 32'd0);
    checkOutput("n4_ones16", 32'(ones4), 32'd16);
    tick();
    checkOutput("n4_done_pulse", 32'(done4), 32'd0);
    for (int k = 0; k < 4; k++) begin
      in_vec4 = 4'($urandom_range(0, 15));
      tick();
      checkOutput("n4_eval", 32'(f4), 32'd1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
